regfile_write_port: RTL and testbench

//   Write side of the 2R/2W register file; counterpart of the 32:1 read-port muxes.

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_wr_decoder.sv | 15 +
 rtl/regfile_write_port.sv | 120 ++++++++++++
 tb/tb_regfile_write_port.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write side.
package regfile_pkg;

  localparam int unsigned BITS  = 5;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned NREGS = 2 ** BITS;

  typedef struct packed {
    logic [BITS-1:0]  addr;
    logic [WIDTH-1:0] data;
  } wr_req_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hold_state_t;

endpackage

// File: rtl/regfile_wr_decoder.sv
// Write-address decoder: binary address to one-hot register enable, gated by en.
module regfile_wr_decoder #(
  parameter int unsigned Bits = 5
) (
  input  logic                 en,
  input  logic [Bits-1:0]      addr,
  output logic [2**Bits-1:0]   sel_c
);

  always_comb begin
    sel_c = '0;
    if (en) sel_c[addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_port.sv
// Dual write port into a 32x32 register bank with one physical write port.
// Optional REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module regfile_write_port
  import regfile_pkg::*;
#(
  parameter int unsigned Bits  = BITS,
  parameter int unsigned Width = WIDTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr0_valid,
  input  logic [Bits-1:0]               wr0_addr,
  input  logic [Width-1:0]              wr0_data,
  output logic                          wr0_ready,
  input  logic                          wr1_valid,
  input  logic [Bits-1:0]               wr1_addr,
  input  logic [Width-1:0]              wr1_data,
  output logic                          wr1_ready,
  output logic                          busy,
  output logic [(2**Bits)*Width-1:0]    rf_q
);

  localparam int unsigned NRegs = 2 ** Bits;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  hold_state_t                  state;
  logic [Bits-1:0]              hold_addr;
  logic [Width-1:0]             hold_data;
  logic                         wr_en;
  logic [Bits-1:0]              wr_addr;
  logic [Width-1:0]             wr_data;
  logic                         capture;
  logic                         xfer0;
  logic                         xfer1;
  logic                         zero0;
  logic                         zero1;
  logic [NRegs-1:0]             sel;
  logic [NRegs-1:0][Width-1:0]  regs;

  // Readies depend only on the hold state so a producer never sees a valid->ready loop.
  assign wr0_ready = (state == IDLE);
  assign wr1_ready = (state == IDLE);
  assign busy      = (state == HOLD);

  assign xfer0 = wr0_valid && (state == IDLE);
  assign xfer1 = wr1_valid && (state == IDLE);
  assign zero0 = ZeroReg && (wr0_addr == '0);
  assign zero1 = ZeroReg && (wr1_addr == '0);

  // Select the single write that reaches the bank this cycle.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wr0_addr;
    wr_data = wr0_data;
    capture = 1'b0;
    if (state == HOLD) begin
      wr_en   = 1'b1;
      wr_addr = hold_addr;
      wr_data = hold_data;
    end else if (xfer0 && xfer1 && (wr0_addr == wr1_addr)) begin
      wr_en   = !zero1;
      wr_addr = wr1_addr;
      wr_data = wr1_data;
    end else if (xfer0 && xfer1 && zero1) begin
      wr_en   = !zero0;
    end else if (xfer0 && xfer1) begin
      wr_en   = !zero0;
      capture = 1'b1;
    end else if (xfer0) begin
      wr_en   = !zero0;
    end else if (xfer1) begin
      wr_en   = !zero1;
      wr_addr = wr1_addr;
      wr_data = wr1_data;
    end
  end

  // Hold-buffer state machine: the younger write waits one cycle for the bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            state     <= HOLD;
            hold_addr <= wr1_addr;
            hold_data <= wr1_data;
          end
        end
        HOLD: state <= IDLE;
      endcase
    end
  end

  regfile_wr_decoder #(.Bits(Bits)) u_dec (
    .en    (wr_en),
    .addr  (wr_addr),
    .sel_c (sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int unsigned i = 0; i < NRegs; i++) begin
        if (sel[i]) regs[i] <= wr_data;
      end
    end
  end

  assign rf_q = regs;

endmodule

// File: tb/tb_regfile_write_port.sv
// Directed, table-driven bench for regfile_write_port.
module tb_regfile_write_port;
  import regfile_pkg::*;

  logic                    clk;
  logic                    rst_n;
  logic                    wr0_valid;
  logic [BITS-1:0]         wr0_addr;
  logic [WIDTH-1:0]        wr0_data;
  logic                    wr0_ready;
  logic                    wr1_valid;
  logic [BITS-1:0]         wr1_addr;
  logic [WIDTH-1:0]        wr1_data;
  logic                    wr1_ready;
  logic                    busy;
  logic [NREGS*WIDTH-1:0]  rf_q;

  int checks;
  int errors;

  typedef struct {
    string     name;
    logic      v0;
    wr_req_t   w0;
    logic      v1;
    wr_req_t   w1;
    logic [BITS-1:0]  ea;
    logic [WIDTH-1:0] ed;
  } vec_t;

  vec_t vecs[6];

`ifdef REGFILE_ZERO_REG_EN
  localparam logic [WIDTH-1:0] Reg0Exp = 32'h0000_0000;
`else
  localparam logic [WIDTH-1:0] Reg0Exp = 32'h0000_FFFF;
`endif

  regfile_write_port dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr0_valid (wr0_valid),
    .wr0_addr  (wr0_addr),
    .wr0_data  (wr0_data),
    .wr0_ready (wr0_ready),
    .wr1_valid (wr1_valid),
    .wr1_addr  (wr1_addr),
    .wr1_data  (wr1_data),
    .wr1_ready (wr1_ready),
    .busy      (busy),
    .rf_q      (rf_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] reg_at(input int idx);
    return rf_q[idx*WIDTH +: WIDTH];
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [BITS-1:0] a0, input logic [WIDTH-1:0] d0,
                       input logic v1, input logic [BITS-1:0] a1, input logic [WIDTH-1:0] d1);
    wr0_valid = v0; wr0_addr = a0; wr0_data = d0;
    wr1_valid = v1; wr1_addr = a1; wr1_data = d1;
  endtask

  task automatic idle_inputs();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < int'(NREGS); i++) check(name, reg_at(i), '0);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0] = '{"single_wr0",   1'b1, '{5'd5,  32'hDEAD_BEEF}, 1'b0, '{5'd0,  32'h0},         5'd5,  32'hDEAD_BEEF};
    vecs[1] = '{"single_wr1",   1'b0, '{5'd0,  32'h0},         1'b1, '{5'd12, 32'h1234_5678}, 5'd12, 32'h1234_5678};
    vecs[2] = '{"same_addr9",   1'b1, '{5'd9,  32'hAA},        1'b1, '{5'd9,  32'hBB},        5'd9,  32'hBB};
    vecs[3] = '{"single_top",   1'b1, '{5'd31, 32'hFFFF_FFFF}, 1'b0, '{5'd0,  32'h0},         5'd31, 32'hFFFF_FFFF};
    vecs[4] = '{"same_addr31",  1'b1, '{5'd31, 32'h1},         1'b1, '{5'd31, 32'h2},         5'd31, 32'h2};
    vecs[5] = '{"zero_reg",     1'b1, '{5'd0,  32'hFFFF},      1'b0, '{5'd0,  32'h0},         5'd0,  Reg0Exp};

    // Reset with valids asserted
    rst_n = 1'b0;
    drive(1'b1, 5'd1, 32'h5, 1'b1, 5'd2, 32'h6);
    repeat (3) step();
    check_all_zero("reset_rf");
    check("reset_ready0", 32'(wr0_ready), 32'd1);
    check("reset_ready1", 32'(wr1_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    idle_inputs();
    rst_n = 1'b1;
    repeat (2) step();
    check_all_zero("post_reset_idle");

    // Single-cycle vectors, none of which occupy the hold buffer
    foreach (vecs[k]) begin
      drive(vecs[k].v0, vecs[k].w0.addr, vecs[k].w0.data, vecs[k].v1, vecs[k].w1.addr, vecs[k].w1.data);
      step();
      idle_inputs();
      check(vecs[k].name, reg_at(int'(vecs[k].ea)), vecs[k].ed);
      check({vecs[k].name, "_busy"}, 32'(busy), 32'd0);
      check({vecs[k].name, "_ready"}, 32'(wr0_ready & wr1_ready), 32'd1);
    end

    // Dual write, different addresses: second write lands one cycle later
    drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd7, 32'h22);
    step();
    idle_inputs();
    check("dual_reg3", reg_at(3), 32'h11);
    check("dual_reg7_pending", reg_at(7), 32'h0);
    check("dual_busy", 32'(busy), 32'd1);
    check("dual_ready0", 32'(wr0_ready), 32'd0);
    check("dual_ready1", 32'(wr1_ready), 32'd0);
    step();
    check("dual_reg7", reg_at(7), 32'h22);
    check("dual_busy_clear", 32'(busy), 32'd0);

    // Back-pressure: a write presented while busy must wait
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
    step();
    check("bp_busy", 32'(busy), 32'd1);
    drive(1'b1, 5'd4, 32'h33, 1'b0, '0, '0);
    step();
    check("bp_reg2", reg_at(2), 32'h2);
    check("bp_reg4_blocked", reg_at(4), 32'h0);
    check("bp_ready", 32'(wr0_ready), 32'd1);
    step();
    idle_inputs();
    check("bp_reg4", reg_at(4), 32'h33);
    check("bp_reg1", reg_at(1), 32'h1);

    // Reset while the hold buffer is full
    drive(1'b1, 5'd10, 32'h55, 1'b1, 5'd11, 32'h66);
    step();
    idle_inputs();
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset_rf");
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_ready", 32'(wr0_ready & wr1_ready), 32'd1);
    step();
    rst_n = 1'b1;
    repeat (2) step();
    check("mid_reset_reg11", reg_at(11), 32'h0);

`ifdef REGFILE_ZERO_REG_EN
    // Younger write to register 0 is discarded without stalling
    drive(1'b1, 5'd6, 32'h77, 1'b1, 5'd0, 32'h88);
    step();
    idle_inputs();
    check("zero_dual_busy", 32'(busy), 32'd0);
    check("zero_dual_reg6", reg_at(6), 32'h77);
    check("zero_dual_reg0", reg_at(0), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
